// File: rtl/arbitro_mem_dados.sv
// arbitro_mem_dados
// Two-port arbiter and sequencer for the nRisc data memory. Port 0 is the
// processor datapath and port 1 is the debug/loader port. Each granted access
// runs OCIOSO -> ACESSO -> ESPERA -> CONCLUI. The request is latched at the
// grant, so a requester's inputs can change once it has been granted.
//
// Ports:
//   clock, reset            system clock, async active-low reset
//   ReqN/EscreveN           request and write flag (1 = write), N = 0,1
//   EnderecoN/DadoN         access address and write data
//   ProntoN                 one-cycle completion pulse to the winner
//   DadoLidoN               read-data register, updated only by port N reads
//   MemEndereco/MemDadoPraEscrever/MemLerMemoria/MemEscreveMemoria
//                           memory side, valid only in ACESSO, else 0
//   MemDadoLido             memory read data (registered inside the memory)
//
// Build option: ARBITRO_RODIZIO_EN selects round-robin on ties; when it is
// undefined, port 0 always wins ties (fixed priority).
module arbitro_mem_dados #(
  parameter int LARGURA   = 8,
  parameter int ENDERECOS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Req0,
  input  logic                 Req1,
  input  logic                 Escreve0,
  input  logic                 Escreve1,
  input  logic [ENDERECOS-1:0] Endereco0,
  input  logic [ENDERECOS-1:0] Endereco1,
  input  logic [LARGURA-1:0]   Dado0,
  input  logic [LARGURA-1:0]   Dado1,
  output logic                 Pronto0,
  output logic                 Pronto1,
  output logic [LARGURA-1:0]   DadoLido0,
  output logic [LARGURA-1:0]   DadoLido1,
  output logic [ENDERECOS-1:0] MemEndereco,
  output logic [LARGURA-1:0]   MemDadoPraEscrever,
  output logic                 MemLerMemoria,
  output logic                 MemEscreveMemoria,
  input  logic [LARGURA-1:0]   MemDadoLido
);

  typedef enum logic [1:0] {OCIOSO, ACESSO, ESPERA, CONCLUI} estado_t;

  estado_t                estado, proximo;
  logic                   escrita;
  logic [ENDERECOS-1:0]   endereco_l;
  logic [LARGURA-1:0]     dado_l;
  logic                   vencedor;
  logic                   venc_nxt;
  logic                   concede;
  logic [1:0]             req;
  logic [LARGURA-1:0]     dado_lido [2];

  assign req     = {Req1, Req0};
  assign concede = (estado == OCIOSO) && (|req);

`ifdef ARBITRO_RODIZIO_EN
  // ultimo starts at 1 so port 0 takes the first tie after reset.
  logic ultimo;

  always_comb begin
    venc_nxt = req[1];
    if (&req) venc_nxt = ~ultimo;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       ultimo <= 1'b1;
    else if (concede) ultimo <= venc_nxt;
  end
`else
  // Port 1 only wins when port 0 is not asking.
  assign venc_nxt = ~req[0];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:  if (|req) proximo = ACESSO;
      ACESSO:  proximo = ESPERA;
      ESPERA:  proximo = CONCLUI;
      CONCLUI: proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  // Request latches; the access in flight only ever sees these.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vencedor   <= 1'b0;
      escrita    <= 1'b0;
      endereco_l <= '0;
      dado_l     <= '0;
    end else if (concede) begin
      vencedor   <= venc_nxt;
      escrita    <= venc_nxt ? Escreve1  : Escreve0;
      endereco_l <= venc_nxt ? Endereco1 : Endereco0;
      dado_l     <= venc_nxt ? Dado1     : Dado0;
    end
  end

  // Memory registered the read at the edge ending ACESSO, so MemDadoLido is
  // stable throughout ESPERA and is captured at the edge ending it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dado_lido[0] <= '0;
      dado_lido[1] <= '0;
    end else if (estado == ESPERA && !escrita) begin
      dado_lido[vencedor] <= MemDadoLido;
    end
  end

  assign DadoLido0 = dado_lido[0];
  assign DadoLido1 = dado_lido[1];

  assign Pronto0 = (estado == CONCLUI) && !vencedor;
  assign Pronto1 = (estado == CONCLUI) &&  vencedor;

  // Decoded only from registered state, so reset clears them at once and no
  // requester input reaches the memory combinationally.
  assign MemEndereco        = (estado == ACESSO) ? endereco_l : '0;
  assign MemDadoPraEscrever = (estado == ACESSO) ? dado_l     : '0;
  assign MemLerMemoria      = (estado == ACESSO) && !escrita;
  assign MemEscreveMemoria  = (estado == ACESSO) &&  escrita;

endmodule

// File: doc/arbitro_mem_dados.md
# arbitro_mem_dados

Two-port arbiter and sequencer for the nRisc data memory (8-bit address, 8-bit data; read data registered on the rising clock edge, write committed on the falling edge). It lets the processor datapath (port 0) and a debug/loader port (port 1) share the single memory. It runs each granted access through a fixed four-state sequence and returns read data and a completion pulse to the winning requester.

## Interface
- LARGURA, 8, data width of all data buses
- ENDERECOS, 8, address width of all address buses
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-low reset
- Req0 / Req1  in  1  access request, port 0 / port 1
- Escreve0 / Escreve1  in  1  1 = write, 0 = read
- Endereco0 / Endereco1  in  ENDERECOS  access address
- Dado0 / Dado1  in  LARGURA  write data
- Pronto0 / Pronto1  out  1  one-cycle completion pulse
- DadoLido0 / DadoLido1  out  LARGURA  read-data register per port
- MemEndereco  out  ENDERECOS  memory address
- MemDadoPraEscrever  out  LARGURA  memory write data
- MemLerMemoria  out  1  memory read enable
- MemEscreveMemoria  out  1  memory write enable
- MemDadoLido  in  LARGURA  memory read data

## Operation
- States: OCIOSO → ACESSO → ESPERA → CONCLUI → OCIOSO. Encoding is free; exactly these four states exist.
- OCIOSO
  - If Req0 or Req1 is high at the rising edge, select a winner and latch its Escreve, Endereco and Dado into internal registers plus a 1-bit vencedor; go to ACESSO.
  - If no request is high, stay in OCIOSO.
- ACESSO
  - MemEndereco and MemDadoPraEscrever are driven from the latched registers.
  - MemLerMemoria = !escrita; MemEscreveMemoria = escrita.
  - Go to ESPERA.
- ESPERA
  - All Mem enables are 0.
  - On a read, DadoLido[vencedor] ← MemDadoLido at the rising edge ending this state.
  - Go to CONCLUI.
- CONCLUI
  - Pronto[vencedor] = 1. The other port's Pronto stays 0.
  - Go to OCIOSO unconditionally.
- Arbitration is round-robin (see Configuration). A 1-bit register ultimo records the last winner. With both requests high, the winner is the port ≠ ultimo. With one request high, that port wins. ultimo is updated on every grant.
- Requester rules
  - A requester holds Req, Escreve, Endereco and Dado stable from assertion until its Pronto.
  - It deasserts Req in the cycle after Pronto. Req still high in that OCIOSO cycle is a new request.
  - Inputs are latched at the grant, so changes after the grant do not affect the access in flight.
- DadoLidoX changes only on a completed read by port X. Its value holds across writes and across the other port's accesses.
- All Mem outputs are decoded from registered state and latches, so no input-to-memory combinational path exists. MemEndereco and MemDadoPraEscrever read 0 outside ACESSO.

## Timing
- Reset values (reset low, immediate):
  - State = OCIOSO, ultimo = 1, so port 0 wins the first tie.
  - Latches = 0.
  - Pronto0/1 = 0, DadoLido0/1 = 0.
  - All Mem outputs = 0.
- Latency: request sampled at rising edge E → ACESSO in cycle E+1 → ESPERA in E+2 → Pronto high in cycle E+3, with DadoLido valid in the same cycle.
- Throughput: one access per 4 cycles. A back-to-back competing request is granted at the edge that ends the OCIOSO cycle following CONCLUI.
- A write commits at the falling edge inside ACESSO. A read is captured by memory at the rising edge that ends ACESSO.
- Reset asserted during ACESSO before the falling edge forces MemEscreveMemoria to 0 immediately, and the write is abandoned.
- Reset asserted in any state drops Pronto without completion; the requester must re-issue.
- Release of reset is sampled synchronously; the first grant is possible at the first rising edge with reset high.
- Address 255 has no special handling and does not wrap.

## Configuration
- ARBITRO_RODIZIO_EN defined: round-robin arbitration as described above.
- ARBITRO_RODIZIO_EN undefined: fixed priority, port 0 always wins ties. The ultimo register is not built. Port 1 can starve under continuous port 0 traffic, which is accepted for this build.

## Test plan
- Reset then Req0 write (Endereco0=8'h10, Dado0=8'hA5), then Req0 read of 8'h10 → Pronto0 in cycle E+3 for each access; DadoLido0=8'hA5; Pronto1 stays 0.
- Req0 and Req1 raised in the same cycle, both reads → port 0 granted first; port 1 Pronto exactly 4 cycles after port 0's. Undefined macro: same order.
- Both requests held continuously for 8 accesses → grants alternate 0,1,0,1… With the macro undefined, port 0 gets all 8 grants.
- Port 1 writes 8'h3C to 8'hFF, then port 0 reads 8'hFF → DadoLido0=8'h3C; DadoLido1 keeps its previous value.
- Assert reset during ACESSO of a write to 8'h20 (before the falling edge), then read 8'h20 → old value returned; Pronto never pulses for the aborted access.
- Change Endereco0 in the cycle after the grant → access uses the latched address; MemLerMemoria and MemEscreveMemoria are never both high.
